// File: rtl/occ_pkg.sv
// Shared constants and the pending-request record for the occurrence-table fetch path.
package occ_pkg;

    localparam int OCC_BLOCK_BYTES   = 64;
    localparam int OCC_BLOCK_LOG2    = 6;
    localparam int OCC_SHIFT_DEFAULT = 7;
    localparam int OCC_TAG_W_DEFAULT = 8;

    typedef struct packed {
        logic [OCC_TAG_W_DEFAULT-1:0] tag;
        logic [OCC_SHIFT_DEFAULT-1:0] offset;
    } occ_pend_t;

endpackage

// File: rtl/occ_pend_fifo.sv
// Small synchronous FIFO with full/empty flags; DEPTH must be a power of two >= 2.
module occ_pend_fifo
    import occ_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = occ_pend_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_r;
    logic [AW:0] rptr_r;
    T            mem_r [DEPTH];

    // Pointer and storage update; the extra pointer bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_r[wptr_r[AW-1:0]] <= wdata;
                wptr_r                <= wptr_r + PTR_ONE;
            end
            if (pop) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    assign rdata = mem_r[rptr_r[AW-1:0]];
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);

endmodule

// File: rtl/occ_fetch.sv
// AXI4-Lite read master fetching 64-byte occurrence blocks in request order.
// Optional statistics counters are enabled by defining OCC_FETCH_STATS_EN.
module occ_fetch
    import occ_pkg::*;
#(
    parameter logic [39:0] BASE_ADDR       = 40'h00_0000_0000,
    parameter int          POS_W           = 34,
    parameter int          TAG_W           = 8,
    parameter int          DW              = 512,
    parameter int          OCC_SHIFT       = OCC_SHIFT_DEFAULT,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [POS_W-1:0]     req_pos,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [39:0]          m_araddr,
    output logic [2:0]           m_arprot,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    input  logic [DW-1:0]        m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [OCC_SHIFT-1:0] rsp_offset,
    output logic                 rsp_err
`ifdef OCC_FETCH_STATS_EN
    ,
    output logic [31:0]          stat_req_cnt,
    output logic [31:0]          stat_ar_stall,
    output logic [15:0]          stat_err_cnt
`endif
);

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [OCC_SHIFT-1:0] offset;
    } pend_t;

    logic        accept_s;
    logic        r_hs_s;
    logic        pend_full_s;
    logic        pend_empty_s;
    pend_t       push_s;
    pend_t       head_s;
    logic [39:0] blk_addr_s;

    // Block address wraps modulo 2^40; segment boundaries need no special case.
    assign blk_addr_s = BASE_ADDR + (40'(req_pos >> OCC_SHIFT) << OCC_BLOCK_LOG2);
    assign push_s     = '{tag: req_tag, offset: req_pos[OCC_SHIFT-1:0]};

    assign req_ready = !rst && (!m_arvalid || m_arready) && !pend_full_s;
    assign accept_s  = req_valid && req_ready;
    assign m_rready  = !rst && !pend_empty_s && (!rsp_valid || rsp_ready);
    assign r_hs_s    = m_rvalid && m_rready;
    assign m_arprot  = 3'b000;

    occ_pend_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (pend_t)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .wdata (push_s),
        .pop   (r_hs_s),
        .rdata (head_s),
        .full  (pend_full_s),
        .empty (pend_empty_s)
    );

    // AR register: a new acceptance always takes priority over retiring the current beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_arvalid <= 1'b0;
            m_araddr  <= 40'h00_0000_0000;
        end else if (accept_s) begin
            m_arvalid <= 1'b1;
            m_araddr  <= blk_addr_s;
        end else if (m_arready) begin
            m_arvalid <= 1'b0;
        end
    end

    // Output register: tag and offset come from the FIFO head since AXI4-Lite returns in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            rsp_offset <= '0;
            rsp_err    <= 1'b0;
        end else if (r_hs_s) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= m_rdata;
            rsp_tag    <= head_s.tag;
            rsp_offset <= head_s.offset;
            rsp_err    <= |m_rresp;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

`ifdef OCC_FETCH_STATS_EN
    // Free-running statistics, wrapping on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_cnt  <= 32'd0;
            stat_ar_stall <= 32'd0;
            stat_err_cnt  <= 16'd0;
        end else begin
            if (accept_s) begin
                stat_req_cnt <= stat_req_cnt + 32'd1;
            end
            if (m_arvalid && !m_arready) begin
                stat_ar_stall <= stat_ar_stall + 32'd1;
            end
            if (r_hs_s && (|m_rresp)) begin
                stat_err_cnt <= stat_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_occ_fetch.sv
// Self-checking bench for occ_fetch: reference queue model, AXI4-Lite ROM slave and directed tests.
module tb_occ_fetch;

    localparam logic [39:0] BASE = 40'h00_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [33:0]  req_pos;
    logic [7:0]   req_tag;
    logic [39:0]  m_araddr;
    logic [2:0]   m_arprot;
    logic         m_arvalid;
    logic         m_arready;
    logic [511:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rvalid;
    logic         m_rready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [511:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic [6:0]   rsp_offset;
    logic         rsp_err;
`ifdef OCC_FETCH_STATS_EN
    logic [31:0]  stat_req_cnt;
    logic [31:0]  stat_ar_stall;
    logic [15:0]  stat_err_cnt;
`endif

    occ_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pos    (req_pos),
        .req_tag    (req_tag),
        .m_araddr   (m_araddr),
        .m_arprot   (m_arprot),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_offset (rsp_offset),
        .rsp_err    (rsp_err)
`ifdef OCC_FETCH_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_ar_stall (stat_ar_stall),
        .stat_err_cnt  (stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: block address from plain division/multiplication.
    function automatic logic [39:0] model_addr(input logic [33:0] pos);
        logic [63:0] a;
        a = 64'(BASE) + (64'(pos) / 64'd128) * 64'd64;
        return a[39:0];
    endfunction

    function automatic logic [511:0] rom_data(input logic [39:0] addr);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) begin
            d[i*64 +: 64] = {24'h0, addr} ^ (64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0000_1111_0000_1111);
        end
        return d;
    endfunction

    typedef struct {
        logic [39:0] addr;
        logic [7:0]  tag;
        logic [6:0]  off;
        logic        err;
    } exp_t;

    typedef struct {
        logic [39:0] addr;
        int          ready;
    } rd_t;

    exp_t        exp_q[$];
    logic [39:0] ar_exp_q[$];
    rd_t         rd_q[$];
    logic        err_hist[$];
    logic [39:0] err_addr = 40'hFF_FFFF_FFFF;
    int          slv_lat  = 3;
    bit          ar_rand  = 1'b0;
    bit          rsp_rand = 1'b0;
    bit          rsp_hold = 1'b0;
    logic [39:0] last_ar  = 40'h0;
    logic [6:0]  last_off = 7'h0;
    logic [511:0] last_data = '0;
    int          rsp_cnt  = 0;
    int          acc_cnt  = 0;
    int          acc_cyc  = 0;

    // AXI4-Lite ROM slave with a fixed read latency and in-order returns.
    initial begin
        logic        ar_hs;
        logic        r_hs;
        logic [39:0] cap;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            ar_hs = m_arvalid && m_arready && !rst;
            r_hs  = m_rvalid && m_rready && !rst;
            cap   = m_araddr;
            if (ar_hs) begin
                if (ar_exp_q.size() == 0) check("ar_unexpected", 64'(cap), 64'hDEAD);
                else check("ar_addr", 64'(cap), 64'(ar_exp_q.pop_front()));
                rd_q.push_back('{addr: cap, ready: cyc + slv_lat});
                last_ar = cap;
            end
            @(posedge clk);
            #1;
            if (rst) rd_q.delete();
            else if (r_hs && rd_q.size() > 0) void'(rd_q.pop_front());
            if (rd_q.size() > 0 && rd_q[0].ready <= cyc) begin
                m_rvalid = 1'b1;
                m_rdata  = rom_data(rd_q[0].addr);
                m_rresp  = (rd_q[0].addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
                m_rvalid = 1'b0;
                m_rdata  = '0;
                m_rresp  = 2'b00;
            end
            m_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Compare process: response order/content and hold-stability of both output registers.
    initial begin
        logic         pv_ar_stall = 1'b0;
        logic [39:0]  pv_araddr   = 40'h0;
        logic         pv_rsp_stall = 1'b0;
        logic [7:0]   pv_tag      = 8'h0;
        logic [511:0] pv_data     = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv_ar_stall  = 1'b0;
                pv_rsp_stall = 1'b0;
            end else begin
                if (pv_ar_stall) begin
                    check("arvalid_held", 64'(m_arvalid), 64'd1);
                    check("araddr_stable", 64'(m_araddr), 64'(pv_araddr));
                end
                if (pv_rsp_stall) begin
                    check("rsp_valid_held", 64'(rsp_valid), 64'd1);
                    check("rsp_tag_held", 64'(rsp_tag), 64'(pv_tag));
                    check_wide("rsp_data_held", rsp_data, pv_data);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_tag), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                        check("rsp_offset", 64'(rsp_offset), 64'(e.off));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check_wide("rsp_data", rsp_data, rom_data(e.addr));
                    end
                    last_off  = rsp_offset;
                    last_data = rsp_data;
                    err_hist.push_back(rsp_err);
                    rsp_cnt++;
                end
                pv_ar_stall  = m_arvalid && !m_arready;
                pv_araddr    = m_araddr;
                pv_rsp_stall = rsp_valid && !rsp_ready;
                pv_tag       = rsp_tag;
                pv_data      = rsp_data;
            end
        end
    end

    // Called just after a posedge; returns just after the posedge following acceptance.
    task automatic send(input logic [33:0] pos, input logic [7:0] tag);
        int n = 0;
        req_valid = 1'b1;
        req_pos   = pos;
        req_tag   = tag;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) break;
            @(posedge clk);
            #1;
        end
        if (n > 200) begin
            check("req_accept_timeout", 64'(n), 64'd0);
        end else begin
            exp_q.push_back('{addr: model_addr(pos), tag: tag, off: pos[6:0],
                              err: (model_addr(pos) == err_addr)});
            ar_exp_q.push_back(model_addr(pos));
            acc_cyc = cyc;
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base_cnt;
        req_valid = 1'b0;
        req_pos   = '0;
        req_tag   = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_rready", 64'(m_rready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_araddr", 64'(m_araddr), 64'd0);
        check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        check("rst_rsp_offset", 64'(rsp_offset), 64'd0);
        check_wide("rst_rsp_data", rsp_data, 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("arprot", 64'(m_arprot), 64'd0);
        @(posedge clk);
        #1;

        // Single request, latency 3: response valid five cycles after acceptance.
        send(34'd0, 8'h11);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", 64'(cyc - acc_cyc), 64'd5);
        check("t1_araddr", 64'(last_ar), 64'h00_0000_0000);
        check("t1_tag", 64'(rsp_tag), 64'h11);
        check("t1_offset", 64'(rsp_offset), 64'd0);
        @(posedge clk);
        #1;
        wait_idle("t1_drain");

        send(34'd389, 8'h22);
        wait_idle("t2_drain");
        check("t2_araddr", 64'(last_ar), 64'h00_0000_00C0);
        check("t2_offset", 64'(last_off), 64'd5);

        send(34'h1_0000_0000, 8'h33);
        wait_idle("t3_drain");
        check("t3_araddr", 64'(last_ar), 64'h00_8000_0000);
        check("t3_segment", 64'(last_ar[39:31]), 64'd1);
        check("t3_offset", 64'(last_off), 64'd0);
        check_wide("t3_data", last_data, rom_data(40'h00_8000_0000));

        // Random arready/rsp_ready, six back-to-back requests.
        ar_rand  = 1'b1;
        rsp_rand = 1'b1;
        @(posedge clk);
        #1;
        base_cnt = rsp_cnt;
        for (int i = 0; i < 6; i++) begin
            send(34'(i * 1000 + i * 3 + 128), 8'h40 + 8'(i));
        end
        wait_idle("t4_drain");
        check("t4_count", 64'(rsp_cnt - base_cnt), 64'd6);
        ar_rand  = 1'b0;
        rsp_rand = 1'b0;

        // Backpressure: four outstanding fill the FIFO.
        rsp_hold = 1'b1;
        slv_lat  = 6;
        @(posedge clk);
        #1;
        base_cnt = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            send(34'(5000 + i * 128 + i), 8'h80 + 8'(i));
        end
        @(negedge clk);
        check("t5_accepted", 64'(acc_cnt - base_cnt), 64'd4);
        check("t5_full_req_ready", 64'(req_ready), 64'd0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("t5_rready_blocked", 64'(m_rready), 64'd0);
        base_cnt = rsp_cnt;
        @(posedge clk);
        #1;
        rsp_hold = 1'b0;
        slv_lat  = 3;
        wait_idle("t5_drain");
        check("t5_count", 64'(rsp_cnt - base_cnt), 64'd4);

        // Error response on the second of two reads, after a fresh reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        err_addr = model_addr(34'd1000);
        err_hist.delete();
        @(posedge clk);
        #1;
        send(34'd300, 8'h51);
        send(34'd1000, 8'h52);
        wait_idle("t6_drain");
        check("t6_resp_count", 64'(err_hist.size()), 64'd2);
        if (err_hist.size() == 2) begin
            check("t6_err_first", 64'(err_hist[0]), 64'd0);
            check("t6_err_second", 64'(err_hist[1]), 64'd1);
        end
`ifdef OCC_FETCH_STATS_EN
        check("t6_stat_req", 64'(stat_req_cnt), 64'd2);
        check("t6_stat_err", 64'(stat_err_cnt), 64'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/occ_fetch.md
# occ_fetch

Upstream AXI4-Lite read master for the occurrence-table memory. Each request carries a BWT position, which the block converts to the byte address of the enclosing 64-byte occurrence block. The block issues single-beat reads with up to MAX_OUTSTANDING in flight and returns each block, in order, tagged with the requester's tag and the position's in-block offset. It sits between the SMEM/backward-extension engine and the occurrence memory: the AXI4-Lite occurrence ROM in simulation, DDR in hardware.

## Interface
- BASE_ADDR, 40'h00_0000_0000: byte address of occurrence block 0.
- POS_W, 34: BWT position width.
- TAG_W, 8: request tag width.
- DW, 512: AXI read data width; equals one occurrence block.
- OCC_SHIFT, 7: log2 of the occurrence interval (positions per block).
- MAX_OUTSTANDING, 4: maximum accepted-but-unreturned requests; power of two, ≥2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid / req_ready  in/out  1  request handshake.
- req_pos  in  POS_W  BWT position.
- req_tag  in  TAG_W  opaque tag, returned with the response.
- m_araddr  out  40  read address.
- m_arprot  out  3  constant 3'b000.
- m_arvalid / m_arready  out/in  1  AR handshake.
- m_rdata  in  DW  read data; byte 0 of the block is in [7:0].
- m_rresp  in  2  read response.
- m_rvalid / m_rready  in/out  1  R handshake.
- rsp_valid / rsp_ready  out/in  1  response handshake.
- rsp_data  out  DW  occurrence block, passed through unmodified.
- rsp_tag  out  TAG_W  tag from the matching request.
- rsp_offset  out  OCC_SHIFT  req_pos[OCC_SHIFT-1:0].
- rsp_err  out  1  set when the matching m_rresp != 2'b00.

## Operation
- Address calculation: m_araddr = BASE_ADDR + ((req_pos >> OCC_SHIFT) << 6), computed in 40 bits with carries beyond bit 39 discarded. Bits [39:31] select the 2 GiB table segment; no special handling at segment boundaries.
- Request acceptance: a request is accepted when req_valid & req_ready.
  - req_ready = (!m_arvalid | m_arready) & !pend_full.
  - On acceptance, {req_tag, offset} is pushed into the pending FIFO (depth MAX_OUTSTANDING), and the AR register is loaded.
- AR register:
  - m_arvalid is set on acceptance and cleared on m_arready unless a new request is accepted in the same cycle.
  - m_araddr stays stable while m_arvalid is high and m_arready is low.
- R channel:
  - m_rready = !pend_empty & (!rsp_valid | rsp_ready).
  - On an R handshake, the FIFO head is popped. The output register loads data, tag, offset and err = |m_rresp.
- Output register:
  - rsp_valid is set on an R handshake.
  - It is cleared on rsp_ready unless a new R handshake occurs in the same cycle.
  - Contents are held while rsp_valid & !rsp_ready.
- Ordering: responses return in request order, which AXI4-Lite guarantees. The pending FIFO supplies the tag, so there is no reorder logic.
- Simultaneous FIFO push and pop: occupancy is unchanged. A push when full cannot occur because req_ready is gated by pend_full.
- Reset mid-operation: the FIFO, AR register and output register are all cleared. In-flight AXI reads are abandoned, so the slave must share rst.
- Reset values: req_ready 0 during rst and 1 afterwards. m_arvalid, m_rready, rsp_valid, rsp_err 0. m_araddr, rsp_data, rsp_tag, rsp_offset 0.

## Timing
- Request accepted in cycle N: m_arvalid is high from cycle N+1.
- R handshake in cycle M: rsp_valid is high from cycle M+1.
- Minimum latency, with m_arready=1 and zero slave latency: 2 cycles plus slave latency, request to response.
- Throughput: one request per cycle while m_arready=1 and the FIFO is not full.
- No combinational path from rsp_ready to req_ready; the only paths are through m_rready to the FIFO.

## Configuration
- OCC_FETCH_STATS_EN defined: adds outputs stat_req_cnt[31:0] (accepted requests), stat_ar_stall[31:0] (cycles with m_arvalid & !m_arready) and stat_err_cnt[15:0] (responses with rsp_err).
  - All three clear on rst and wrap on overflow.
- Undefined: these ports and counters do not exist.

## Structure
- Package occ_pkg: OCC_BLOCK_BYTES=64, the OCC_SHIFT default, and the typedef occ_pend_t = struct {tag, offset}.
- Sub-module occ_pend_fifo: synchronous FIFO parameterised on depth and type, with full/empty flags. It holds occ_pend_t and can be reused.

## Test plan
- Single request, pos=0, tag=8'h11, slave latency 3 → araddr 40'h0, rsp_tag 8'h11, rsp_offset 0, rsp_valid 5 cycles after acceptance.
- pos=389 (3·128+5) → araddr BASE_ADDR+40'hC0, rsp_offset 5.
- pos=2^32 → araddr 40'h80_0000_00, i.e. bits[39:31]=1, offset 0 → data from segment 1.
- Random arready → m_araddr constant while arvalid & !arready. Six back-to-back requests → tags returned in order.
- rsp_ready held 0, MAX_OUTSTANDING=4 → exactly 4 accepted, then req_ready=0 and m_rready=0 after the first response. Releasing rsp_ready → all 4 drain in order.
- m_rresp=2'b10 on the second of two reads → rsp_err 0 then 1. With OCC_FETCH_STATS_EN: stat_req_cnt=2, stat_err_cnt=1.
